ncl_th_gates: RTL and testbench
===============================

// Module: ncl_th_gates
// PURPOSE
//  Clocked emulation of the NCL threshold-gate primitives TH12, TH22 and TH22N,
//  WIDTH lanes each, for the multirail pipeline (completion OR, C-element
//  registers, init-able input stage).
//  TH12 is combinational 1-of-2 (OR). TH22/TH22N are 2-of-2 hysteresis gates
//  (C-elements) whose state is held in flops sampled on clk.
// PARAMETERS
//  WIDTH   1   number of independent gate lanes per gate type
// PORTS
//  clk          in   1      single clock; all TH22/TH22N state updates on rising edge
//  init_n       in   1      asynchronous active-low reset; clears all gate state to 0
//  th12_a       in   WIDTH  TH12 input A per lane
//  th12_b       in   WIDTH  TH12 input B per lane
//  th12_z       out  WIDTH  TH12 output: a|b, combinational
//  th22_a       in   WIDTH  TH22 input A per lane
//  th22_b       in   WIDTH  TH22 input B per lane
//  th22_z       out  WIDTH  TH22 output (registered)
//  th22n_a      in   WIDTH  TH22N input A per lane
//  th22n_b      in   WIDTH  TH22N input B per lane
//  th22n_init   in   WIDTH  TH22N gate-local init, active high, per lane
//  th22n_z      out  WIDTH  TH22N output (registered)
// BEHAVIOUR
//  - Reset: init_n=0 asynchronously forces th22_z=0, th22n_z=0 (NULL);
//    th12_z is not state and follows a|b even during reset.
//  - TH12: th12_z[i] = th12_a[i] | th12_b[i]; zero latency, no hysteresis.
//  - TH22 per lane, at rising clk edge when init_n=1:
//      a=1,b=1 -> z<=1 (set);  a=0,b=0 -> z<=0 (clear);  a!=b -> z holds.
//  - TH22N: identical to TH22, except th22n_init[i]=1 at the edge forces z[i]<=0,
//    overriding a/b (init has priority over set). th22n_init is synchronous.
//  - Latency: 1 clk from input change to TH22/TH22N output change; output stable
//    between edges. Inputs are sampled only at edges (glitches between edges ignored).
//  - Simultaneous events: init_n low overrides everything; th22n_init overrides a=b=1.
//  - Release of init_n: first edge after deassertion evaluates normally from state 0.
//  - Lanes are fully independent; no cross-lane coupling.
//  - No X propagation allowed from reset state: every flop has a defined reset value.
// STRUCTURE
//  - Package ncl_pkg: dual-rail typedef (2-bit {rail1,rail0}), constants
//    NCL_NULL=2'b00, NCL_DATA0=2'b01, NCL_DATA1=2'b10, and a function
//    th22_next(a,b,z) returning the hysteresis next state.
//  - Sub-module th22_cell (one lane: clk, init_n, a, b, local_init, z);
//    TH22 lanes instantiate it with local_init tied 0, TH22N lanes with
//    th22n_init[i]. TH12 is inline continuous assignment via generate loop.
// TESTING
//  1. Reset: hold init_n=0 with all a=b=1 for 3 edges -> th22_z=0, th22n_z=0;
//     th12_z=all-ones throughout.
//  2. TH12 truth table (ab=00,01,10,11) -> th12_z=0,1,1,1 with no clock edge needed.
//  3. TH22 hysteresis sequence ab=00,10,11,01,00,10 -> z after each edge
//     =0,0,1,1,0,0.
//  4. TH22N: a=b=1 with th22n_init=1 -> z stays 0; drop th22n_init -> z=1 on
//     next edge; then a=1,b=0 -> z holds 1.
//  5. Async reset mid-operation: th22_z=1, pulse init_n low between edges ->
//     z=0 immediately without a clk edge; after release with ab=10, z stays 0.
//  6. WIDTH=4 lane independence: lane0 ab=11, lane1 ab=10, lane2 ab=00, lane3
//     ab=11 with th22n_init[3]=1 -> th22n_z=4'b0001; th22_z=4'b1001.

Source files
------------

// File: rtl/ncl_pkg.sv
// ----------------------------------------------------------------------------
// ncl_pkg
//   Shared NCL (Null Convention Logic) definitions for the multirail pipeline.
//   - ncl_dr_t      : dual-rail signal, packed as {rail1, rail0}
//   - NCL_NULL/DATA0/DATA1 : the three legal dual-rail codes
//   - th22_next()   : next state of a 2-of-2 hysteresis gate (C-element)
//   No ports; imported by ncl_th_gates and th22_cell.
// ----------------------------------------------------------------------------
package ncl_pkg;

    typedef logic [1:0] ncl_dr_t;

    localparam ncl_dr_t NCL_NULL  = 2'b00;
    localparam ncl_dr_t NCL_DATA0 = 2'b01;
    localparam ncl_dr_t NCL_DATA1 = 2'b10;

    // C-element: set when both inputs are high, clear when both are low,
    // otherwise keep the current output. Written as the majority of (a, b, z).
    function automatic logic th22_next(input logic a, input logic b, input logic z);
        return (a & b) | (z & (a | b));
    endfunction

endpackage

// File: rtl/ncl_th_gates_th22_cell.sv
// ----------------------------------------------------------------------------
// th22_cell
//   One lane of a clocked TH22 / TH22N gate.
//   Ports:
//     clk        in  rising-edge clock; state updates only here
//     init_n     in  asynchronous active-low reset, forces z to NULL (0)
//     a, b       in  gate inputs, sampled at the clock edge
//     local_init in  synchronous gate-local init, active high; wins over a=b=1
//     z          out registered gate output
// ----------------------------------------------------------------------------
module th22_cell
    import ncl_pkg::*;
(
    input  logic clk,
    input  logic init_n,
    input  logic a,
    input  logic b,
    input  logic local_init,
    output logic z
);

    logic z_q;
    logic z_d;

    always_comb begin
        z_d = th22_next(a, b, z_q);
        if (local_init) begin
            z_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/ncl_th_gates.sv
// ----------------------------------------------------------------------------
// ncl_th_gates
//   Clocked emulation of the NCL threshold gates TH12, TH22 and TH22N,
//   WIDTH independent lanes of each.
//   Ports:
//     clk         in  clock for TH22/TH22N state
//     init_n      in  asynchronous active-low reset of all gate state
//     th12_a/b    in  [WIDTH] TH12 inputs
//     th12_z      out [WIDTH] a|b, combinational (unaffected by reset)
//     th22_a/b    in  [WIDTH] TH22 inputs
//     th22_z      out [WIDTH] registered TH22 output
//     th22n_a/b   in  [WIDTH] TH22N inputs
//     th22n_init  in  [WIDTH] synchronous per-lane init, active high
//     th22n_z     out [WIDTH] registered TH22N output
// ----------------------------------------------------------------------------
module ncl_th_gates
    import ncl_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [WIDTH-1:0] th12_a,
    input  logic [WIDTH-1:0] th12_b,
    output logic [WIDTH-1:0] th12_z,
    input  logic [WIDTH-1:0] th22_a,
    input  logic [WIDTH-1:0] th22_b,
    output logic [WIDTH-1:0] th22_z,
    input  logic [WIDTH-1:0] th22n_a,
    input  logic [WIDTH-1:0] th22n_b,
    input  logic [WIDTH-1:0] th22n_init,
    output logic [WIDTH-1:0] th22n_z
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        // TH12 holds no state, so it keeps following its inputs during reset.
        assign th12_z[i] = th12_a[i] | th12_b[i];

        // Plain TH22: same cell with the local init tied off.
        th22_cell u_th22 (
            .clk        (clk),
            .init_n     (init_n),
            .a          (th22_a[i]),
            .b          (th22_b[i]),
            .local_init (1'b0),
            .z          (th22_z[i])
        );

        th22_cell u_th22n (
            .clk        (clk),
            .init_n     (init_n),
            .a          (th22n_a[i]),
            .b          (th22n_b[i]),
            .local_init (th22n_init[i]),
            .z          (th22n_z[i])
        );
    end

endmodule

// File: tb/tb_ncl_th_gates.sv
module tb_ncl_th_gates;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         init_n;
    logic [W-1:0] th12_a, th12_b, th12_z;
    logic [W-1:0] th22_a, th22_b, th22_z;
    logic [W-1:0] th22n_a, th22n_b, th22n_init, th22n_z;

    int passed = 0;
    int total  = 0;

    // Reference state: per-lane gate outputs derived from the threshold rule.
    logic [W-1:0] m22;
    logic [W-1:0] m22n;

    ncl_th_gates #(.WIDTH(W)) dut (
        .clk        (clk),
        .init_n     (init_n),
        .th12_a     (th12_a),
        .th12_b     (th12_b),
        .th12_z     (th12_z),
        .th22_a     (th22_a),
        .th22_b     (th22_b),
        .th22_z     (th22_z),
        .th22n_a    (th22n_a),
        .th22n_b    (th22n_b),
        .th22n_init (th22n_init),
        .th22n_z    (th22n_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Threshold-count model: count high inputs; 2 -> 1, 0 -> 0, 1 -> hold.
    function automatic logic thr2(input logic a, input logic b, input logic z);
        int n;
        n = int'(a) + int'(b);
        if (n == 2) return 1'b1;
        if (n == 0) return 1'b0;
        return z;
    endfunction

    // One clock edge; the model updates from the inputs present at the edge.
    task automatic edge_step();
        @(posedge clk);
        if (init_n) begin
            for (int i = 0; i < W; i++) begin
                m22[i]  = thr2(th22_a[i], th22_b[i], m22[i]);
                m22n[i] = th22n_init[i] ? 1'b0 : thr2(th22n_a[i], th22n_b[i], m22n[i]);
            end
        end else begin
            m22  = '0;
            m22n = '0;
        end
        #1;
    endtask

    initial begin
        logic [1:0] seq_ab [6];
        logic [W-1:0] seq_z [6];
        logic [W-1:0] tab_z [4];

        m22  = '0;
        m22n = '0;

        // Reset held with every input high.
        init_n = 1'b0;
        th12_a = '1; th12_b = '1;
        th22_a = '1; th22_b = '1;
        th22n_a = '1; th22n_b = '1; th22n_init = '0;
        #2;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            chk("rst_th22", th22_z, 4'b0000);
            chk("rst_th22n", th22n_z, 4'b0000);
            chk("rst_th12", th12_z, 4'b1111);
        end

        // TH12 truth table, no clock edge involved.
        tab_z[0] = 4'b0000; tab_z[1] = 4'b1111; tab_z[2] = 4'b1111; tab_z[3] = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            th12_a = {W{k[1]}};
            th12_b = {W{k[0]}};
            #1;
            chk($sformatf("th12_ab%0d%0d", k[1], k[0]), th12_z, tab_z[k]);
        end

        // Release reset with all inputs low.
        th22_a = '0; th22_b = '0; th22n_a = '0; th22n_b = '0;
        @(negedge clk);
        init_n = 1'b1;

        // TH22 hysteresis sequence.
        seq_ab[0] = 2'b00; seq_ab[1] = 2'b10; seq_ab[2] = 2'b11;
        seq_ab[3] = 2'b01; seq_ab[4] = 2'b00; seq_ab[5] = 2'b10;
        seq_z[0] = 4'b0000; seq_z[1] = 4'b0000; seq_z[2] = 4'b1111;
        seq_z[3] = 4'b1111; seq_z[4] = 4'b0000; seq_z[5] = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            th22_a = {W{seq_ab[k][1]}};
            th22_b = {W{seq_ab[k][0]}};
            edge_step();
            chk($sformatf("th22_seq%0d", k), th22_z, seq_z[k]);
        end

        // TH22N local init beats a=b=1, then releases.
        th22n_a = '1; th22n_b = '1; th22n_init = '1;
        edge_step();
        chk("th22n_init_hold0", th22n_z, 4'b0000);
        th22n_init = '0;
        edge_step();
        chk("th22n_set", th22n_z, 4'b1111);
        th22n_b = '0;
        edge_step();
        chk("th22n_hold1", th22n_z, 4'b1111);

        // Asynchronous reset between edges.
        th22_a = '1; th22_b = '1;
        edge_step();
        chk("th22_pre_async", th22_z, 4'b1111);
        #2;
        init_n = 1'b0;
        m22 = '0; m22n = '0;
        #1;
        chk("async_th22", th22_z, 4'b0000);
        chk("async_th22n", th22n_z, 4'b0000);
        #1;
        init_n = 1'b1;
        th22_a = '1; th22_b = '0;
        edge_step();
        chk("post_release_th22", th22_z, 4'b0000);

        // Lane independence, starting from cleared state.
        th22_a = 4'b1011; th22_b = 4'b1001;
        th22n_a = 4'b1011; th22n_b = 4'b1001; th22n_init = 4'b1000;
        edge_step();
        chk("lanes_th22", th22_z, 4'b1001);
        chk("lanes_th22n", th22n_z, 4'b0001);

        // Randomized traffic against the threshold model.
        for (int k = 0; k < 60; k++) begin
            th12_a = W'($urandom); th12_b = W'($urandom);
            th22_a = W'($urandom); th22_b = W'($urandom);
            th22n_a = W'($urandom); th22n_b = W'($urandom);
            th22n_init = (($urandom % 4) == 0) ? W'($urandom) : '0;
            #1;
            chk("rnd_th12", th12_z, th12_a | th12_b);
            edge_step();
            chk("rnd_th22", th22_z, m22);
            chk("rnd_th22n", th22n_z, m22n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
